// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types for the RC4 key-scheduling engine.
// Provides the FSM state enum and the key-byte index width helper.
package ksa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    CAP_I,
    RD_J,
    CAP_J,
    WR_I,
    WR_J,
    FIN
  } state_t;

  // Width of a counter that indexes n key bytes (at least 1 bit).
  function automatic int kidx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: picks byte idx of the latched key, byte 0 = MSB byte.
// Ports: key (KEY_BYTES*8) in, idx (KW) in, kbyte (8) out.
module ksa_key_sel
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int KW        = kidx_w(KEY_BYTES)
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [KW-1:0]          idx,
  output logic [7:0]             kbyte
);

  always_comb begin
    kbyte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (idx == KW'(n)) kbyte = key[(KEY_BYTES-n)*8-1 -: 8];
    end
  end

endmodule

// File: rtl/ksa_sched_engine.sv
// ksa_sched_engine: RC4 init + key-schedule swap over a 1-port S-RAM.
// Ports: clk, reset, start, init_only, key -> busy, done, mem_addr/wdata/wren; mem_rdata in.
module ksa_sched_engine
  import ksa_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_only,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int KW = kidx_w(KEY_BYTES);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  state_t                   state;
  logic [ADDR_W-1:0]        i;
  logic [ADDR_W-1:0]        j;
  logic [KW-1:0]            k;
  logic [KEY_BYTES*8-1:0]   key_q;
  logic                     io_q;
  logic [DATA_W-1:0]        si;

  logic [7:0]               kbyte;
  logic [ADDR_W-1:0]        i_nx;
  logic [ADDR_W-1:0]        j_n;
  logic [KW-1:0]            k_nx;

  ksa_key_sel #(
    .KEY_BYTES(KEY_BYTES),
    .KW       (KW)
  ) u_key_sel (
    .key  (key_q),
    .idx  (k),
    .kbyte(kbyte)
  );

  assign i_nx = i + ADDR_W'(1);
  // k tracks i mod KEY_BYTES without a divider
  assign k_nx = (k == K_LAST) ? '0 : k + KW'(1);
  // j update wraps naturally in ADDR_W bits
  assign j_n  = j + ADDR_W'(mem_rdata) + ADDR_W'(kbyte);

  // Outputs are registered: each branch sets them for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      key_q     <= '0;
      io_q      <= 1'b0;
      si        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q     <= key;
            io_q      <= init_only;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          if (i == LAST) begin
            i        <= '0;
            k        <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
            if (io_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= RD_I;
            end
          end else begin
            i         <= i_nx;
            k         <= k_nx;
            mem_addr  <= i_nx;
            mem_wdata <= DATA_W'(i_nx);
          end
        end
        RD_I: state <= CAP_I;
        CAP_I: begin
          si       <= mem_rdata;
          j        <= j_n;
          mem_addr <= j_n;
          state    <= RD_J;
        end
        RD_J: state <= CAP_J;
        CAP_J: begin
          // S[j] goes straight to the S[i] write
          mem_addr  <= i;
          mem_wdata <= mem_rdata;
          mem_wren  <= 1'b1;
          state     <= WR_I;
        end
        WR_I: begin
          mem_addr  <= j;
          mem_wdata <= si;
          state     <= WR_J;
        end
        WR_J: begin
          mem_wren <= 1'b0;
          if (i == LAST) begin
            i     <= '0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            i        <= i_nx;
            k        <= k_nx;
            mem_addr <= i_nx;
            state    <= RD_I;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
